// File: rtl/eth_tx_sched.sv
// eth_tx_sched: transmit scheduler feeding the single Ethernet frame builder.
// Latches ARP-reply, UDP-ack and telemetry requests into pending slots. ARP has
// fixed top priority, and ack/telemetry alternate round-robin. One frame is
// issued at a time, then a completion timeout and an inter-frame gap follow.
// The telemetry peer is learned from the most recent udp_done.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   arp_req, arp_src_*              ARP who-has pulse and requester endpoint
//   udp_done, udp_src_*             UDP frame-done pulse and peer endpoint
//   tlm_req                         telemetry frame request pulse
//   tx_start, tx_kind, tx_dst_*,    frame issue to the builder (registered);
//   tx_src_port                       fields hold until the next tx_start
//   tx_done                         builder completion pulse
//   busy, peer_valid                status
//   drop_cnt, abort_cnt             saturating drop / timeout counters
module eth_tx_sched #(
  parameter logic [15:0] IFG_CYCLES = 16'd24,
  parameter logic [23:0] TX_TIMEOUT = 24'd1_000_000,
  parameter logic [15:0] LOCAL_PORT = 16'd5005
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_req,
  input  logic [47:0] arp_src_mac,
  input  logic [31:0] arp_src_ip,
  input  logic        udp_done,
  input  logic [47:0] udp_src_mac,
  input  logic [31:0] udp_src_ip,
  input  logic [15:0] udp_src_port,
  input  logic        tlm_req,
  output logic        tx_start,
  output logic [1:0]  tx_kind,
  output logic [47:0] tx_dst_mac,
  output logic [31:0] tx_dst_ip,
  output logic [15:0] tx_dst_port,
  output logic [15:0] tx_src_port,
  input  logic        tx_done,
  output logic        busy,
  output logic        peer_valid,
  output logic [15:0] drop_cnt,
  output logic [15:0] abort_cnt
);

  typedef enum logic [1:0] {StIdle, StWaitDone, StGap} state_e;

  localparam logic [1:0] KindArp = 2'd0;
  localparam logic [1:0] KindAck = 2'd1;
  localparam logic [1:0] KindTlm = 2'd2;

  state_e      state_q;
  logic        arp_p_q, ack_p_q, tlm_p_q;
  logic        rr_q;  // 0: ack preferred over telemetry, 1: telemetry preferred
  logic [47:0] arp_mac_q, ack_mac_q, peer_mac_q;
  logic [31:0] arp_ip_q, ack_ip_q, peer_ip_q;
  logic [15:0] ack_port_q, peer_port_q;
  logic [23:0] tmo_q;
  logic [15:0] gap_q;

  logic        idle;
  logic        grant_arp, grant_ack, grant_tlm;
  logic        drop_arp, drop_ack, drop_tlm;
  logic [16:0] drop_sum;
  logic [15:0] drop_cnt_d;

  always_comb begin
    idle      = (state_q == StIdle);
    grant_arp = idle & arp_p_q;
    grant_ack = idle & ~arp_p_q & ack_p_q & (~tlm_p_q | ~rr_q);
    grant_tlm = idle & ~arp_p_q & tlm_p_q & (~ack_p_q | rr_q);
    // A request landing on its slot's grant cycle refills the slot; not a drop.
    drop_arp  = arp_req & arp_p_q & ~grant_arp;
    drop_ack  = udp_done & ack_p_q & ~grant_ack;
    drop_tlm  = tlm_req & (~peer_valid | (tlm_p_q & ~grant_tlm));
    drop_sum  = {1'b0, drop_cnt} + {16'd0, drop_arp} + {16'd0, drop_ack} + {16'd0, drop_tlm};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      arp_p_q     <= 1'b0;
      ack_p_q     <= 1'b0;
      tlm_p_q     <= 1'b0;
      rr_q        <= 1'b0;
      arp_mac_q   <= '0;
      arp_ip_q    <= '0;
      ack_mac_q   <= '0;
      ack_ip_q    <= '0;
      ack_port_q  <= '0;
      peer_mac_q  <= '0;
      peer_ip_q   <= '0;
      peer_port_q <= '0;
      peer_valid  <= 1'b0;
      tmo_q       <= '0;
      gap_q       <= '0;
      tx_start    <= 1'b0;
      tx_kind     <= KindArp;
      tx_dst_mac  <= '0;
      tx_dst_ip   <= '0;
      tx_dst_port <= '0;
      tx_src_port <= '0;
      drop_cnt    <= '0;
      abort_cnt   <= '0;
    end else begin
      tx_start <= 1'b0;
      arp_p_q  <= arp_req | (arp_p_q & ~grant_arp);
      ack_p_q  <= udp_done | (ack_p_q & ~grant_ack);
      tlm_p_q  <= (tlm_req & peer_valid) | (tlm_p_q & ~grant_tlm);
      drop_cnt <= drop_cnt_d;

      if (arp_req) begin
        arp_mac_q <= arp_src_mac;
        arp_ip_q  <= arp_src_ip;
      end
      if (udp_done) begin
        ack_mac_q   <= udp_src_mac;
        ack_ip_q    <= udp_src_ip;
        ack_port_q  <= udp_src_port;
        peer_mac_q  <= udp_src_mac;
        peer_ip_q   <= udp_src_ip;
        peer_port_q <= udp_src_port;
        peer_valid  <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (grant_arp || grant_ack || grant_tlm) begin
            tx_start <= 1'b1;
            tmo_q    <= TX_TIMEOUT;
            state_q  <= StWaitDone;
            if (grant_arp) begin
              tx_kind     <= KindArp;
              tx_dst_mac  <= arp_mac_q;
              tx_dst_ip   <= arp_ip_q;
              tx_dst_port <= 16'd0;
              tx_src_port <= 16'd0;
            end else if (grant_ack) begin
              tx_kind     <= KindAck;
              tx_dst_mac  <= ack_mac_q;
              tx_dst_ip   <= ack_ip_q;
              tx_dst_port <= ack_port_q;
              tx_src_port <= LOCAL_PORT;
              rr_q        <= ~rr_q;
            end else begin
              // Telemetry goes to whichever peer is known at grant time.
              tx_kind     <= KindTlm;
              tx_dst_mac  <= peer_mac_q;
              tx_dst_ip   <= peer_ip_q;
              tx_dst_port <= peer_port_q;
              tx_src_port <= LOCAL_PORT;
              rr_q        <= ~rr_q;
            end
          end
        end
        StWaitDone: begin
          if (tx_done) begin
            gap_q   <= IFG_CYCLES;
            state_q <= StGap;
          end else if (tmo_q <= 24'd1) begin
            // Expires TX_TIMEOUT cycles after tx_start.
            if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
            gap_q   <= IFG_CYCLES;
            state_q <= StGap;
          end else begin
            tmo_q <= tmo_q - 24'd1;
          end
        end
        StGap: begin
          if (gap_q == 16'd0) state_q <= StIdle;
          else                gap_q   <= gap_q - 16'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Self-checking bench for eth_tx_sched: vector table of single requests plus
// hand-written sequences for priority, overwrite, timeout, reset and
// set-over-clear. Expected frames go into a queue and are popped per tx_start.
module tb_eth_tx_sched;

  localparam int Ifg = 24;
  localparam int Tmo = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arp_req = 1'b0;
  logic [47:0] arp_src_mac = '0;
  logic [31:0] arp_src_ip = '0;
  logic        udp_done = 1'b0;
  logic [47:0] udp_src_mac = '0;
  logic [31:0] udp_src_ip = '0;
  logic [15:0] udp_src_port = '0;
  logic        tlm_req = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_start, busy, peer_valid;
  logic [1:0]  tx_kind;
  logic [47:0] tx_dst_mac;
  logic [31:0] tx_dst_ip;
  logic [15:0] tx_dst_port, tx_src_port, drop_cnt, abort_cnt;

  eth_tx_sched #(
    .IFG_CYCLES(16'(Ifg)),
    .TX_TIMEOUT(24'(Tmo)),
    .LOCAL_PORT(16'd5005)
  ) dut (
    .clk(clk), .rst(rst),
    .arp_req(arp_req), .arp_src_mac(arp_src_mac), .arp_src_ip(arp_src_ip),
    .udp_done(udp_done), .udp_src_mac(udp_src_mac), .udp_src_ip(udp_src_ip),
    .udp_src_port(udp_src_port), .tlm_req(tlm_req),
    .tx_start(tx_start), .tx_kind(tx_kind), .tx_dst_mac(tx_dst_mac),
    .tx_dst_ip(tx_dst_ip), .tx_dst_port(tx_dst_port), .tx_src_port(tx_src_port),
    .tx_done(tx_done), .busy(busy), .peer_valid(peer_valid),
    .drop_cnt(drop_cnt), .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
    logic [15:0] sport;
  } exp_t;

  typedef struct {
    logic [1:0]  req;   // 0 arp_req, 1 udp_done, 2 tlm_req
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
    exp_t        exp;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   starts = 0;
  int   last_start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Scoreboard: every tx_start must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && tx_start === 1'b1) begin
      exp_t e;
      starts++;
      last_start_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_start: got kind %0d, required no start", tx_kind);
      end else begin
        e = exp_q.pop_front();
        check("kind", 64'(tx_kind), 64'(e.kind));
        check("dst_mac", 64'(tx_dst_mac), 64'(e.mac));
        check("dst_ip", 64'(tx_dst_ip), 64'(e.ip));
        check("dst_port", 64'(tx_dst_port), 64'(e.port));
        check("src_port", 64'(tx_src_port), 64'(e.sport));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_arp(input logic [47:0] m, input logic [31:0] ip);
    arp_req = 1'b1; arp_src_mac = m; arp_src_ip = ip;
    step();
    arp_req = 1'b0;
  endtask

  task automatic pulse_udp(input logic [47:0] m, input logic [31:0] ip, input logic [15:0] p);
    udp_done = 1'b1; udp_src_mac = m; udp_src_ip = ip; udp_src_port = p;
    step();
    udp_done = 1'b0;
  endtask

  task automatic pulse_tlm();
    tlm_req = 1'b1;
    step();
    tlm_req = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic wait_start(input int s0, input int budget, output int at);
    for (int i = 0; i < budget && starts == s0; i++) step();
    check("start_seen", 64'(starts != s0), 64'd1);
    at = last_start_cyc;
  endtask

  task automatic wait_idle(input int budget, output int at);
    for (int i = 0; i < budget && busy !== 1'b0; i++) step();
    check("idle_reached", 64'(busy), 64'd0);
    at = cyc;
  endtask

  function automatic exp_t mk(input logic [1:0] k, input logic [47:0] m, input logic [31:0] ip,
                              input logic [15:0] p, input logic [15:0] sp);
    exp_t e;
    e.kind = k; e.mac = m; e.ip = ip; e.port = p; e.sport = sp;
    return e;
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  localparam logic [47:0] MacA = 48'h02AABBCCDDEE;
  localparam logic [47:0] MacU1 = 48'h021122334455;
  localparam logic [47:0] MacU2 = 48'h026677889900;
  localparam logic [47:0] MacU3 = 48'h02DEADBEEF01;

  initial begin
    vec_t vecs[5];
    int   s0, sc, dc, ic, g;

    vecs[0] = '{2'd0, MacA, 32'h0A0A0A01, 16'd0, mk(2'd0, MacA, 32'h0A0A0A01, 16'd0, 16'd0)};
    vecs[1] = '{2'd1, MacU1, 32'hC0A80002, 16'd4000,
                mk(2'd1, MacU1, 32'hC0A80002, 16'd4000, 16'd5005)};
    vecs[2] = '{2'd2, 48'd0, 32'd0, 16'd0, mk(2'd2, MacU1, 32'hC0A80002, 16'd4000, 16'd5005)};
    vecs[3] = '{2'd1, MacU2, 32'hC0A80003, 16'd1234,
                mk(2'd1, MacU2, 32'hC0A80003, 16'd1234, 16'd5005)};
    vecs[4] = '{2'd2, 48'd0, 32'd0, 16'd0, mk(2'd2, MacU2, 32'hC0A80003, 16'd1234, 16'd5005)};

    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_tx_kind", 64'(tx_kind), 64'd0);
    check("rst_dst_mac", 64'(tx_dst_mac), 64'd0);
    check("rst_dst_ip", 64'(tx_dst_ip), 64'd0);
    check("rst_dst_port", 64'(tx_dst_port), 64'd0);
    check("rst_src_port", 64'(tx_src_port), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_peer_valid", 64'(peer_valid), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_abort_cnt", 64'(abort_cnt), 64'd0);

    // Telemetry with no peer is discarded
    s0 = starts;
    pulse_tlm();
    repeat (6) step();
    check("tlm_nopeer_starts", 64'(starts - s0), 64'd0);
    check("tlm_nopeer_drop", 64'(drop_cnt), 64'd1);
    check("tlm_nopeer_busy", 64'(busy), 64'd0);

    // Vector table: one request each, latency and inter-frame gap checked
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].exp);
      s0 = starts;
      dc = cyc;
      case (vecs[i].req)
        2'd0:    pulse_arp(vecs[i].mac, vecs[i].ip);
        2'd1:    pulse_udp(vecs[i].mac, vecs[i].ip, vecs[i].port);
        default: pulse_tlm();
      endcase
      wait_start(s0, 10, sc);
      check("req_to_start", 64'(sc - dc), 64'd2);
      check("busy_at_start", 64'(busy), 64'd1);
      repeat (3) step();
      dc = cyc;
      pulse_done();
      wait_idle(60, ic);
      check("done_to_idle", 64'(ic - dc), 64'(Ifg + 2));
    end
    check("peer_valid", 64'(peer_valid), 64'd1);
    check("drop_after_vecs", 64'(drop_cnt), 64'd1);

    // Priority and round-robin: all three at once -> ARP, ack, then tlm before re-pended ack
    exp_q.push_back(mk(2'd0, MacA, 32'h0A0A0A02, 16'd0, 16'd0));
    exp_q.push_back(mk(2'd1, MacU3, 32'hC0A80004, 16'd4001, 16'd5005));
    s0 = starts;
    arp_req = 1'b1; arp_src_mac = MacA; arp_src_ip = 32'h0A0A0A02;
    udp_done = 1'b1; udp_src_mac = MacU3; udp_src_ip = 32'hC0A80004; udp_src_port = 16'd4001;
    tlm_req = 1'b1;
    step();
    arp_req = 1'b0; udp_done = 1'b0; tlm_req = 1'b0;
    wait_start(s0, 10, sc);
    repeat (2) step();
    s0 = starts;
    dc = cyc;
    pulse_done();
    wait_start(s0, 60, sc);
    check("done_to_next_start", 64'(sc - dc), 64'(Ifg + 3));
    // Re-pend ack while ack is in flight; tlm is still waiting and now leads.
    exp_q.push_back(mk(2'd2, MacU1, 32'hC0A80009, 16'd777, 16'd5005));
    exp_q.push_back(mk(2'd1, MacU1, 32'hC0A80009, 16'd777, 16'd5005));
    pulse_udp(MacU1, 32'hC0A80009, 16'd777);
    check("drop_after_prio", 64'(drop_cnt), 64'd1);
    s0 = starts;
    pulse_done();
    wait_start(s0, 60, sc);
    s0 = starts;
    pulse_done();
    wait_start(s0, 60, sc);

    // Overwrite: two ARPs while busy -> one frame to the second IP
    exp_q.push_back(mk(2'd0, MacA, 32'h0A0A0A0B, 16'd0, 16'd0));
    pulse_arp(MacA, 32'h0A0A0A0A);
    pulse_arp(MacA, 32'h0A0A0A0B);
    check("drop_overwrite", 64'(drop_cnt), 64'd2);
    s0 = starts;
    pulse_done();
    wait_start(s0, 60, sc);
    pulse_done();
    wait_idle(60, ic);
    repeat (10) step();
    check("no_extra_start", 64'(exp_q.size()), 64'd0);

    // Timeout: no tx_done; abort after Tmo cycles, then the pending ack goes out
    exp_q.push_back(mk(2'd0, MacA, 32'h0A0A0A0C, 16'd0, 16'd0));
    s0 = starts;
    pulse_arp(MacA, 32'h0A0A0A0C);
    wait_start(s0, 10, g);
    exp_q.push_back(mk(2'd1, MacU2, 32'hC0A8000A, 16'd9000, 16'd5005));
    pulse_udp(MacU2, 32'hC0A8000A, 16'd9000);
    s0 = starts;
    while (cyc < g + Tmo - 1) step();
    check("abort_before", 64'(abort_cnt), 64'd0);
    step();
    check("abort_after", 64'(abort_cnt), 64'd1);
    check("busy_in_gap", 64'(busy), 64'd1);
    wait_start(s0, 60, sc);
    check("timeout_to_start", 64'(sc - g), 64'(Tmo + Ifg + 2));

    // Reset mid-WAIT_DONE with an ack pending; late tx_done must be ignored
    pulse_udp(MacU3, 32'hC0A8000B, 16'd1111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    s0 = starts;
    pulse_done();
    repeat (40) step();
    check("rst_mid_starts", 64'(starts - s0), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_kind", 64'(tx_kind), 64'd0);
    check("rst_mid_dst_mac", 64'(tx_dst_mac), 64'd0);
    check("rst_mid_dst_port", 64'(tx_dst_port), 64'd0);
    check("rst_mid_src_port", 64'(tx_src_port), 64'd0);
    check("rst_mid_peer", 64'(peer_valid), 64'd0);
    check("rst_mid_drop", 64'(drop_cnt), 64'd0);
    check("rst_mid_abort", 64'(abort_cnt), 64'd0);
    exp_q.delete();

    // Set wins over clear: second ARP lands on the grant cycle of the first
    exp_q.push_back(mk(2'd0, MacA, 32'h0A000001, 16'd0, 16'd0));
    exp_q.push_back(mk(2'd0, MacU1, 32'h0A000002, 16'd0, 16'd0));
    s0 = starts;
    arp_req = 1'b1; arp_src_mac = MacA; arp_src_ip = 32'h0A000001;
    step();
    arp_src_mac = MacU1; arp_src_ip = 32'h0A000002;
    step();
    arp_req = 1'b0;
    wait_start(s0, 10, sc);
    check("setclr_drop", 64'(drop_cnt), 64'd0);
    s0 = starts;
    dc = cyc;
    pulse_done();
    wait_start(s0, 60, sc);
    check("setclr_restart", 64'(sc - dc), 64'(Ifg + 3));
    pulse_done();
    wait_idle(60, ic);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_tx_sched.md
# eth_tx_sched

Transmit scheduler between the Ethernet/IPv4 receive parser and the single Ethernet frame builder. It has three frame requesters:

- ARP replies, triggered by the parser's ARP who-has pulse.
- UDP acknowledgements, triggered by the parser's UDP frame-done pulse.
- Periodic telemetry frames from the motor PID status logic.

The block latches each request with its destination, arbitrates fixed/round-robin, and issues one frame at a time to the builder. It enforces an inter-frame gap and a completion timeout, and learns the telemetry peer from the last accepted UDP frame.

## Interface
- IFG_CYCLES, 16'd24: idle cycles after each tx_done/abort before the next tx_start.
- TX_TIMEOUT, 24'd1_000_000: cycles allowed in WAIT_DONE before abort.
- LOCAL_PORT, 16'd5005: source UDP port placed in tx_src_port for UDP kinds.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- arp_req  in  1  one-cycle pulse: ARP who-has for us
- arp_src_mac  in  48  requester MAC, valid with arp_req
- arp_src_ip  in  32  requester IP, valid with arp_req
- udp_done  in  1  one-cycle pulse: matching UDP frame completed
- udp_src_mac / udp_src_ip / udp_src_port  in  48/32/16  peer endpoint, valid with udp_done
- tlm_req  in  1  one-cycle pulse: telemetry frame wanted
- tx_start  out  1  one-cycle pulse, builder begins frame
- tx_kind  out  2  0 = ARP reply, 1 = UDP ack, 2 = telemetry
- tx_dst_mac / tx_dst_ip / tx_dst_port  out  48/32/16  destination, stable from tx_start until next tx_start
- tx_src_port  out  16  LOCAL_PORT for kinds 1/2, 0 for ARP
- tx_done  in  1  one-cycle pulse, builder finished
- busy  out  1  high in any state other than IDLE
- peer_valid  out  1  telemetry peer learned
- drop_cnt  out  16  saturating count of overwritten/discarded requests
- abort_cnt  out  16  saturating count of timeouts

## Operation
- Three pending slots: arp_p, ack_p, tlm_p. Each ARP and ack slot holds its own endpoint fields.
- arp_req sets arp_p and loads the ARP fields. If arp_p was already set, the fields are overwritten and drop_cnt is incremented.
- udp_done sets ack_p and loads the ack fields. It also loads the peer registers (mac/ip/port) and sets peer_valid. If ack_p was already set, the fields are overwritten and drop_cnt is incremented.
- tlm_req handling:
  - With peer_valid = 0, the request is discarded and drop_cnt is incremented.
  - If tlm_p is already set, drop_cnt is incremented.
  - Otherwise tlm_p is set.
- Telemetry destination is taken from the peer registers at grant time, not at request time.
- Arbitration in IDLE:
  - ARP is always highest priority.
  - Between ack and telemetry, round-robin on a 1-bit last-grant flag. After reset, ack is preferred.
- FSM states are IDLE, WAIT_DONE and GAP.
  - IDLE with any slot pending: drive the outputs for the winner, pulse tx_start, clear the winner's slot, flip the last-grant flag if the winner is ack or telemetry, load the timeout counter with TX_TIMEOUT, and go to WAIT_DONE.
  - WAIT_DONE on tx_done: go to GAP.
  - WAIT_DONE when the counter reaches 0 without tx_done: increment abort_cnt and go to GAP.
  - GAP: count IFG_CYCLES cycles, then go to IDLE. IFG_CYCLES = 0 means GAP lasts exactly 1 cycle.
- A request arriving on the same cycle its slot is cleared by grant leaves the slot set with the new fields (set wins over clear). It is not counted as a drop.
- tx_done outside WAIT_DONE is ignored.
- Counters saturate at 16'hFFFF.
- Reset mid-frame: all slots, peer_valid, counters and the FSM are cleared, and no tx_start is issued. A tx_done arriving later is ignored.

## Timing
- Reset values: tx_start=0, tx_kind=0, tx_dst_*=0, tx_src_port=0, busy=0, peer_valid=0, drop_cnt=0, abort_cnt=0. FSM=IDLE, last-grant flag selects ack.
- A request pulse sampled at edge k sets its slot after edge k.
- With FSM in IDLE, tx_start is high for the cycle after edge k+1. Request-to-start latency is 2 cycles. Destination fields are valid in the same cycle as tx_start.
- busy rises with tx_start and falls on entry to IDLE.
- tx_done at edge d leads to IDLE after edge d+IFG_CYCLES+1. The earliest next tx_start is one cycle later.
- The timeout abort occurs TX_TIMEOUT cycles after tx_start.
- peer_valid rises the cycle after the first udp_done.

## Test plan
- Single ARP: arp_req with mac 02:AA:BB:CC:DD:EE, ip 10.10.10.1. Expect tx_start 2 cycles later with kind 0, those fields, and tx_src_port 0. tx_done, then the next start is no earlier than 26 cycles later.
- Telemetry before peer: tlm_req with no prior udp_done. Expect no tx_start and drop_cnt=1. Then udp_done from port 4000 followed by tlm_req: expect kind 1, then kind 2, with tx_dst_port 4000 and tx_src_port 5005.
- Priority/round-robin: ack, tlm and arp all pending in the same cycle. Expect grant order ARP, ack, tlm. Re-pend ack and tlm: expect order tlm, ack.
- Overwrite: two arp_req with different IPs while busy. Expect one ARP frame to the second IP and drop_cnt incremented by 1.
- Timeout: TX_TIMEOUT=100 and tx_done never sent. Expect abort_cnt=1 after 100 cycles, then GAP, then the next pending request is issued.
- Reset mid-WAIT_DONE: assert rst, then send tx_done. Expect all outputs at reset values, no tx_start, and counters at 0.
